// File: rtl/button_conditioner_pkg.sv
// Shared button indices and default timing for the button conditioner.
// Timing defaults are derived from the 25 MHz pixel clock.
package button_conditioner_pkg;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DROP  = 2;
    localparam int NUM_BTNS  = 3;

    localparam int CLK_HZ           = 25_000_000;
    localparam int DEBOUNCE_MS      = 10;
    localparam int REPEAT_DELAY_MS  = 500;
    localparam int REPEAT_PERIOD_MS = 150;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int DEFAULT_DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS);
    localparam int DEFAULT_REPEAT_DELAY    = ms_to_cycles(REPEAT_DELAY_MS);
    localparam int DEFAULT_REPEAT_PERIOD   = ms_to_cycles(REPEAT_PERIOD_MS);

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-FF synchroniser, counter debounce, stable level and
// a single-cycle registered pulse on each accepted press.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any agreement between the synchronised level and the stable level
    // throws away the progress made so far.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = stable_q & ~stable_prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
            press_q       <= 1'b0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            press_q       <= press_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Three debounced buttons to one-cycle move/drop commands with conflict
// resolution. Define AUTO_REPEAT_EN to add auto-repeat on the move buttons.
module button_conditioner
    import button_conditioner_pkg::*;
#(
`ifdef AUTO_REPEAT_EN
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
`endif
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk_25MHz,
    input  logic       rst,
    input  logic       btn_right_raw,
    input  logic       btn_left_raw,
    input  logic       btn_drop_raw,
    output logic       move_right,
    output logic       move_left,
    output logic       drop_piece,
    output logic [2:0] btn_state
);

    logic [NUM_BTNS-1:0] raw_in;
    logic [NUM_BTNS-1:0] stable;
    logic [NUM_BTNS-1:0] press;
    logic [NUM_BTNS-1:0] rep_pulse;
    logic [NUM_BTNS-1:0] raw_pulse;
    logic                move_right_q, move_right_d;
    logic                move_left_q, move_left_d;
    logic                drop_piece_q, drop_piece_d;

    assign raw_in = {btn_drop_raw, btn_left_raw, btn_right_raw};

    genvar gi;
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk_25MHz),
            .rst    (rst),
            .raw    (raw_in[gi]),
            .stable (stable[gi]),
            .press  (press[gi])
        );
    end

`ifdef AUTO_REPEAT_EN
    localparam int RCW = $clog2(REPEAT_DELAY + 1);

    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_repeat
        if (gi == BTN_DROP) begin : g_none
            assign rep_pulse[gi] = 1'b0;
        end else begin : g_move
            logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
            logic           rep_q, rep_d;

            // Counter holds cycles elapsed since the press pulse, so it restarts
            // at 1; after each repeat it is rewound by one period.
            always_comb begin
                rep_cnt_d = '0;
                rep_d     = 1'b0;
                if (press[gi]) begin
                    rep_cnt_d = RCW'(1);
                end else if (stable[gi]) begin
                    if (rep_cnt_q == RCW'(REPEAT_DELAY - 1)) begin
                        rep_d     = 1'b1;
                        rep_cnt_d = RCW'(REPEAT_DELAY - REPEAT_PERIOD);
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_25MHz or posedge rst) begin
                if (rst) begin
                    rep_cnt_q <= '0;
                    rep_q     <= 1'b0;
                end else begin
                    rep_cnt_q <= rep_cnt_d;
                    rep_q     <= rep_d;
                end
            end

            assign rep_pulse[gi] = rep_q;
        end
    end
`else
    assign rep_pulse = '0;
`endif

    // Drop wins outright; opposing moves in the same cycle cancel.
    always_comb begin
        raw_pulse    = press | rep_pulse;
        drop_piece_d = raw_pulse[BTN_DROP];
        move_right_d = raw_pulse[BTN_RIGHT] & ~raw_pulse[BTN_LEFT] & ~raw_pulse[BTN_DROP];
        move_left_d  = raw_pulse[BTN_LEFT] & ~raw_pulse[BTN_RIGHT] & ~raw_pulse[BTN_DROP];
    end

    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            move_right_q <= 1'b0;
            move_left_q  <= 1'b0;
            drop_piece_q <= 1'b0;
        end else begin
            move_right_q <= move_right_d;
            move_left_q  <= move_left_d;
            drop_piece_q <= drop_piece_d;
        end
    end

    assign move_right = move_right_q;
    assign move_left  = move_left_q;
    assign drop_piece = drop_piece_q;
    assign btn_state  = stable;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and random checks of button_conditioner against a window-based
// behavioural model of debounce, pulse timing, conflicts and auto-repeat.
module tb_button_conditioner;

    localparam int D  = 8;
    localparam int RD = 40;
    localparam int RP = 10;
`ifdef AUTO_REPEAT_EN
    localparam int AR_PULSES = 7;
`else
    localparam int AR_PULSES = 1;
`endif

    logic       clk_25MHz = 1'b0;
    logic       rst = 1'b0;
    logic       btn_right_raw = 1'b0;
    logic       btn_left_raw = 1'b0;
    logic       btn_drop_raw = 1'b0;
    logic       move_right, move_left, drop_piece;
    logic [2:0] btn_state;

    always #10 clk_25MHz = ~clk_25MHz;

    button_conditioner #(
`ifdef AUTO_REPEAT_EN
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
`endif
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk_25MHz     (clk_25MHz),
        .rst           (rst),
        .btn_right_raw (btn_right_raw),
        .btn_left_raw  (btn_left_raw),
        .btn_drop_raw  (btn_drop_raw),
        .move_right    (move_right),
        .move_left     (move_left),
        .drop_piece    (drop_piece),
        .btn_state     (btn_state)
    );

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;

    // Reference model, index 0=right, 1=left, 2=drop
    bit m_d1[3], m_d2[3];
    bit m_win[3][$];
    bit m_stable[3], m_rise[3], m_rawp[3], m_out[3], m_rep_valid[3];
    int m_press_edge[3];

    // Per-scenario observations
    int   n_pulse[3];
    int   first_pulse[3];
    int   first_state_r;
    logic [2:0] state_or;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_d1[b] = 0; m_d2[b] = 0; m_win[b].delete();
            m_stable[b] = 0; m_rise[b] = 0; m_rawp[b] = 0; m_out[b] = 0;
            m_rep_valid[b] = 0; m_press_edge[b] = 0;
        end
    endtask

    function automatic bit window_disagrees(input int b);
        if (m_win[b].size() < D) return 1'b0;
        for (int i = 0; i < m_win[b].size(); i++)
            if (m_win[b][i] == m_stable[b]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic reset_obs();
        for (int b = 0; b < 3; b++) begin
            n_pulse[b] = 0;
            first_pulse[b] = -1;
        end
        first_state_r = -1;
        state_or = 3'b000;
    endtask

    task automatic model_edge();
        bit raw[3];
        bit old_st[3];
        edge_n++;
        if (rst) return;
        raw[0] = btn_right_raw; raw[1] = btn_left_raw; raw[2] = btn_drop_raw;
        m_out[2] = m_rawp[2];
        m_out[0] = m_rawp[0] & ~m_rawp[1] & ~m_rawp[2];
        m_out[1] = m_rawp[1] & ~m_rawp[0] & ~m_rawp[2];
        for (int b = 0; b < 3; b++) begin
            old_st[b] = m_stable[b];
            m_rawp[b] = m_rise[b];
            if (m_rise[b]) begin
                m_rep_valid[b] = 1;
                m_press_edge[b] = edge_n;
            end
`ifdef AUTO_REPEAT_EN
            if (b < 2 && old_st[b] && m_rep_valid[b] && !m_rise[b]) begin
                int dt;
                dt = edge_n - m_press_edge[b];
                if (dt >= RD && (dt - RD) % RP == 0) m_rawp[b] = 1;
            end
`endif
            m_win[b].push_back(m_d2[b]);
            if (m_win[b].size() > D) void'(m_win[b].pop_front());
            m_rise[b] = 0;
            if (window_disagrees(b)) begin
                m_stable[b] = ~m_stable[b];
                m_rise[b] = m_stable[b];
            end
            if (!m_stable[b]) m_rep_valid[b] = 0;
            m_d2[b] = m_d1[b];
            m_d1[b] = raw[b];
        end
    endtask

    task automatic check_all();
        chk("move_right", 32'(move_right), 32'(m_out[0]));
        chk("move_left", 32'(move_left), 32'(m_out[1]));
        chk("drop_piece", 32'(drop_piece), 32'(m_out[2]));
        chk("btn_state", 32'(btn_state), 32'({m_stable[2], m_stable[1], m_stable[0]}));
        if (move_right === 1'b1) begin n_pulse[0]++; if (first_pulse[0] < 0) first_pulse[0] = edge_n; end
        if (move_left === 1'b1)  begin n_pulse[1]++; if (first_pulse[1] < 0) first_pulse[1] = edge_n; end
        if (drop_piece === 1'b1) begin n_pulse[2]++; if (first_pulse[2] < 0) first_pulse[2] = edge_n; end
        if (btn_state[0] === 1'b1 && first_state_r < 0) first_state_r = edge_n;
        state_or = state_or | btn_state;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_25MHz);
            model_edge();
            @(negedge clk_25MHz);
            check_all();
        end
    endtask

    int k;
    int hold[3];

    initial begin
        model_reset();
        reset_obs();
        #2 rst = 1'b1;
        #3;
        chk("reset_outputs", 32'({move_right, move_left, drop_piece}), 32'd0);
        chk("reset_state", 32'(btn_state), 32'd0);
        step(3);
        rst = 1'b0;
        step(3);

        // Clean press on right
        reset_obs();
        k = edge_n + 1;
        btn_right_raw = 1'b1;
        step(100);
        btn_right_raw = 1'b0;
        step(20);
        chk("clean_count", n_pulse[0], 1);
        chk("clean_latency", first_pulse[0] - k, D + 3);
        chk("clean_state_latency", first_state_r - k, D + 1);
        chk("clean_others", n_pulse[1] + n_pulse[2], 0);

        // Bounce on left never accepted
        reset_obs();
        btn_left_raw = 1'b1; step(5);
        btn_left_raw = 1'b0; step(2);
        btn_left_raw = 1'b1; step(6);
        btn_left_raw = 1'b0; step(20);
        chk("bounce_count", n_pulse[1], 0);
        chk("bounce_state", 32'(state_or), 32'd0);

        // Left and right on the same edge cancel
        reset_obs();
        btn_left_raw = 1'b1; btn_right_raw = 1'b1;
        step(30);
        chk("lr_state", 32'(btn_state), 32'b011);
        chk("lr_count", n_pulse[0] + n_pulse[1], 0);
        btn_left_raw = 1'b0; btn_right_raw = 1'b0;
        step(20);

        // Drop beats right
        reset_obs();
        btn_drop_raw = 1'b1; btn_right_raw = 1'b1;
        step(30);
        btn_drop_raw = 1'b0; btn_right_raw = 1'b0;
        step(20);
        chk("dr_drop_count", n_pulse[2], 1);
        chk("dr_right_count", n_pulse[0], 0);

        // Reset in the middle of debouncing a held drop
        reset_obs();
        btn_drop_raw = 1'b1;
        step(6);
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_outputs", 32'({move_right, move_left, drop_piece, btn_state}), 32'd0);
        step(3);
        rst = 1'b0;
        k = edge_n + 1;
        step(30);
        chk("midrst_count", n_pulse[2], 1);
        chk("midrst_latency", first_pulse[2] - k, D + 3);
        btn_drop_raw = 1'b0;
        step(20);

        // Long hold on right: single pulse, or press plus repeats
        reset_obs();
        btn_right_raw = 1'b1;
        step(95);
        btn_right_raw = 1'b0;
        step(60);
        chk("hold_count", n_pulse[0], AR_PULSES);
        chk("hold_others", n_pulse[1] + n_pulse[2], 0);

        // Random bouncing on all three buttons
        for (int b = 0; b < 3; b++) hold[b] = 0;
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    logic v;
                    v = 1'($urandom_range(0, 1));
                    hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 60))
                                                          : int'($urandom_range(1, 12));
                    case (b)
                        0: btn_right_raw = v;
                        1: btn_left_raw = v;
                        default: btn_drop_raw = v;
                    endcase
                end
                hold[b]--;
            end
            step(1);
        end
        btn_right_raw = 1'b0; btn_left_raw = 1'b0; btn_drop_raw = 1'b0;
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
